// File: rtl/coef_fetch_pkg.sv
// Shared types and geometry for the coefficient fetch sequencer.
package coef_fetch_pkg;

    localparam int CFS_ADDR_W     = 15;
    localparam int CFS_DATA_W     = 32;
    localparam int CFS_LEN_W      = 12;
    localparam int CFS_FIFO_DEPTH = 4;
    localparam int CFS_PTR_W      = $clog2(CFS_FIFO_DEPTH);
    localparam int CFS_CNT_W      = CFS_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/coef_fetch_seq_if.sv
// Valid/ready coefficient stream towards the MFCC datapath.
interface coef_fetch_seq_if
    import coef_fetch_pkg::*;
#(
    parameter int DW = CFS_DATA_W
) ();

    logic [DW-1:0] coef_data;
    logic          coef_valid;
    logic          coef_ready;
    logic          coef_last;

    modport master (output coef_data, output coef_valid, output coef_last, input coef_ready);
    modport slave  (input coef_data, input coef_valid, input coef_last, output coef_ready);

endinterface

// File: rtl/coef_fifo.sv
// Small synchronous FIFO holding returned words plus their end-of-transfer tag.
module coef_fifo
    import coef_fetch_pkg::*;
#(
    parameter int DW    = CFS_DATA_W + 1,
    parameter int DEPTH = CFS_FIFO_DEPTH,
    parameter int PTR_W = CFS_PTR_W,
    parameter int CNT_W = CFS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [DW-1:0]    pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push & ~full;
    assign rd_en    = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/coef_fetch_seq.sv
// Streams a contiguous run of coefficient reads out of the eight-bank memory
// controller and hands the returned words to the MFCC datapath.
//   state    | meaning
//   ST_IDLE  | system path owns the banks, waiting for start
//   ST_FETCH | issuing reads while FIFO credit allows
//   ST_DRAIN | all reads issued, waiting for the last word to be taken
module coef_fetch_seq
    import coef_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH_8_MEM = CFS_ADDR_W,
    parameter int DATA_WIDTH       = CFS_DATA_W,
    parameter int LEN_WIDTH        = CFS_LEN_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH_8_MEM-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]        length,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH_8_MEM-1:0] mem_addr,
    output logic                        mem_addr_sel,
    output logic                        mem_cen_sel,
    input  logic [DATA_WIDTH-1:0]       mem_data_in,
    coef_fetch_seq_if.master            coef
);

    state_t                      state;
    state_t                      state_nx;
    logic [ADDR_WIDTH_8_MEM-1:0] addr_cnt;
    logic [ADDR_WIDTH_8_MEM-1:0] addr_src;
    logic [LEN_WIDTH-1:0]        len_q;
    logic [LEN_WIDTH-1:0]        issued;
    logic [LEN_WIDTH-1:0]        issued_inc;
    logic                        issue;
    logic                        load;
    logic                        done_nx;
    logic                        last_nx;
    logic                        credit_ok;
    logic                        inflight;
    logic                        cen_last;
    logic                        inflight_last;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [DATA_WIDTH:0]         fifo_head;
    logic [CFS_CNT_W-1:0]        fifo_count;

    assign issued_inc = issued + LEN_WIDTH'(1);
    assign addr_src   = load ? base_addr : addr_cnt;
    assign fifo_push  = inflight;
    assign fifo_pop   = ~fifo_empty & coef.coef_ready;

    // The issue decision is registered, so credit is judged on next-cycle
    // occupancy plus the read currently on the bus.
    assign credit_ok = ~(fifo_full & ~fifo_pop) &&
                       ((int'(fifo_count) + int'(fifo_push) - int'(fifo_pop)
                         + int'(mem_cen_sel)) < CFS_FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        load     = 1'b0;
        done_nx  = 1'b0;
        last_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        load     = 1'b1;
                        issue    = 1'b1;
                        last_nx  = (length == LEN_WIDTH'(1));
                        state_nx = last_nx ? ST_DRAIN : ST_FETCH;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    last_nx = (issued_inc == len_q);
                    if (last_nx) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && fifo_head[DATA_WIDTH]) done_nx = 1'b1;
                if (done && fifo_empty && !inflight) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_addr      <= '0;
            mem_addr_sel  <= 1'b0;
            mem_cen_sel   <= 1'b0;
            addr_cnt      <= '0;
            len_q         <= '0;
            issued        <= '0;
            cen_last      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            busy          <= (state_nx != ST_IDLE);
            done          <= done_nx;
            mem_addr_sel  <= (state_nx != ST_IDLE);
            mem_cen_sel   <= issue;
            cen_last      <= last_nx;
            inflight      <= mem_cen_sel;
            inflight_last <= cen_last;
            if (load) len_q <= length;
            if (issue) begin
                mem_addr <= addr_src;
                addr_cnt <= addr_src + ADDR_WIDTH_8_MEM'(1);
                issued   <= load ? LEN_WIDTH'(1) : issued_inc;
            end
        end
    end

    coef_fifo #(
        .DW    (DATA_WIDTH + 1),
        .DEPTH (CFS_FIFO_DEPTH),
        .PTR_W (CFS_PTR_W),
        .CNT_W (CFS_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({inflight_last, mem_data_in}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign coef.coef_valid = ~fifo_empty;
    assign coef.coef_data  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign coef.coef_last  = ~fifo_empty & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_coef_fetch_seq.sv
// Bench for coef_fetch_seq: memory responder, random backpressure, and a
// transfer-level scoreboard of expected addresses and words.
module tb_coef_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] base_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;
    logic [14:0] mem_addr;
    logic        mem_addr_sel;
    logic        mem_cen_sel;
    logic [31:0] mem_data_in;

    coef_fetch_seq_if #(.DW(32)) cif ();

    coef_fetch_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_addr_sel (mem_addr_sel),
        .mem_cen_sel  (mem_cen_sel),
        .mem_data_in  (mem_data_in),
        .coef         (cif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int c0 = 0;
    int ready_mode = 0;
    logic [31:0] salt = 32'h0;
    bit mon_en = 1'b0;

    logic [14:0] exp_addr [$];
    logic [32:0] exp_word [$];
    int n_issue, n_acc, n_done, first_cen, first_valid, done_cyc, busy_fall, issue_at10;
    bit busy_seen, prev_busy;

    logic        s_cen = 1'b0;
    logic [14:0] s_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return (32'(a) * 32'h9E3779B1) ^ salt;
    endfunction

    always @(posedge clk) cyc++;

    // Memory controller stand-in: one-cycle read latency, junk otherwise.
    always @(negedge clk) begin
        s_cen  = mem_cen_sel;
        s_addr = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_data_in = s_cen ? mem_word(s_addr) : $urandom;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       cif.coef_ready = 1'b1;
            1:       cif.coef_ready = ($urandom_range(0, 99) < 60);
            default: cif.coef_ready = ((cyc - c0) >= 10);
        endcase
    end

    always @(negedge clk) begin
        int rel;
        logic [32:0] w;
        rel = cyc - c0;
        if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop)
            chk("fifo_overflow", 1, 0);
        if (mon_en) begin
            if (mem_cen_sel) begin
                n_issue++;
                if (first_cen < 0) first_cen = rel;
                chk("addr_sel_on_issue", mem_addr_sel, 1);
                if (exp_addr.size() > 0) chk("addr", mem_addr, exp_addr.pop_front());
                else chk("extra_issue", 1, 0);
            end
            if (cif.coef_valid && first_valid < 0) first_valid = rel;
            if (cif.coef_valid && cif.coef_ready) begin
                n_acc++;
                if (exp_word.size() > 0) begin
                    w = exp_word.pop_front();
                    chk("data", cif.coef_data, w[31:0]);
                    chk("last", cif.coef_last, w[32]);
                end else begin
                    chk("extra_word", 1, 0);
                end
            end
            if (done) begin
                n_done++;
                done_cyc = rel;
            end
            if (rel == 10) issue_at10 = n_issue;
            if (busy) busy_seen = 1'b1;
            if (prev_busy && !busy) busy_fall = rel;
            prev_busy = busy;
        end
    end

    task automatic clear_mon();
        n_issue = 0; n_acc = 0; n_done = 0;
        first_cen = -1; first_valid = -1; done_cyc = -1; busy_fall = -1; issue_at10 = -1;
        busy_seen = 1'b0;
        exp_addr.delete();
        exp_word.delete();
    endtask

    task automatic kick(input logic [14:0] b, input logic [11:0] n, input bit poke);
        logic [14:0] a;
        clear_mon();
        salt = $urandom;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 15'(i);
            exp_addr.push_back(a);
            exp_word.push_back({(i == int'(n) - 1), mem_word(a)});
        end
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1; base_addr = b; length = n;
        @(posedge clk); #1;
        if (poke) begin
            start = 1'b1; base_addr = 15'h0100; length = 12'd5;
        end else begin
            start = 1'b0; base_addr = 15'($urandom); length = 12'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(n_done > 0 && (cyc - c0) >= done_cyc + 3) && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", (n_done > 0), 1);
    endtask

    task automatic end_checks(input int n);
        chk("issues", n_issue, n);
        chk("accepted", n_acc, n);
        chk("done_pulses", n_done, 1);
        chk("addr_left", exp_addr.size(), 0);
        chk("words_left", exp_word.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic timing_checks(input int n);
        chk("first_issue_cyc", first_cen, 1);
        chk("first_valid_cyc", first_valid, 3);
        chk("done_cyc", done_cyc, n + 3);
        chk("busy_fall_cyc", busy_fall, n + 4);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_addr_sel"}, mem_addr_sel, 0);
        chk({tag, "_cen"}, mem_cen_sel, 0);
        chk({tag, "_valid"}, cif.coef_valid, 0);
        chk({tag, "_last"}, cif.coef_last, 0);
        chk({tag, "_data"}, cif.coef_data, 0);
    endtask

    initial begin
        logic [14:0] b;
        int n;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        cif.coef_ready = 1'b1; mem_data_in = '0;
        clear_mon();
        prev_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        ready_mode = 0;
        kick(15'h0000, 12'd8, 1'b0);
        wait_done(200);
        end_checks(8);
        timing_checks(8);

        kick(15'h7FFE, 12'd4, 1'b0);
        wait_done(200);
        end_checks(4);
        timing_checks(4);

        ready_mode = 2;
        kick(15'h1000, 12'd16, 1'b0);
        wait_done(400);
        end_checks(16);
        chk("issues_while_stalled", issue_at10, 4);

        ready_mode = 0;
        kick(15'h1234, 12'd0, 1'b0);
        wait_done(50);
        chk("len0_issues", n_issue, 0);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_done_pulses", n_done, 1);
        chk("len0_busy_seen", busy_seen, 0);

        kick(15'h2ABC, 12'd1, 1'b1);
        wait_done(100);
        repeat (10) @(posedge clk);
        end_checks(1);
        timing_checks(1);

        kick(15'h0300, 12'd20, 1'b0);
        while ((cyc - c0) < 5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        @(negedge clk);
        check_idle_outputs("midrst");
        repeat (12) @(posedge clk);
        chk("midrst_issues", n_issue, 0);
        chk("midrst_words", n_acc, 0);
        chk("midrst_done", n_done, 0);

        kick(15'h0A00, 12'd6, 1'b0);
        wait_done(200);
        end_checks(6);
        timing_checks(6);

        for (int r = 0; r < 12; r++) begin
            ready_mode = (r % 3 == 0) ? 0 : 1;
            if ($urandom_range(0, 2) == 0) b = 15'h7FF0 + 15'($urandom_range(0, 15));
            else b = 15'($urandom);
            n = $urandom_range(1, 40);
            kick(b, 12'(n), ($urandom_range(0, 1) == 1));
            wait_done(n * 40 + 100);
            end_checks(n);
            if (ready_mode == 0) timing_checks(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coef_fetch_seq.md
# coef_fetch_seq

Read sequencer that sits directly upstream of the eight-bank coefficient memory controller. On a start command it streams a contiguous run of 15-bit word addresses into the controller's address input with the chip-enable select raised, captures the returned 32-bit words (one-cycle memory read latency), and delivers them on a valid/ready stream to the MFCC datapath (filterbank / DCT coefficient consumers). A small credit-controlled FIFO absorbs downstream backpressure without losing in-flight reads.

## Interface
- `ADDR_WIDTH_8_MEM`, 15, word address width into the eight-bank controller (top 3 bits select bank)
- `DATA_WIDTH`, 32, coefficient word width
- `LEN_WIDTH`, 12, width of the transfer length
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥ 3)

- `clk`  in  1  clock; one clock domain, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only when `busy`=0
- `base_addr`  in  ADDR_WIDTH_8_MEM  first word address, sampled with `start`
- `length`  in  LEN_WIDTH  number of words, sampled with `start`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse at end of transfer
- `mem_addr`  out  ADDR_WIDTH_8_MEM  to controller `addr_8_mem_in`
- `mem_addr_sel`  out  1  to controller address select; 1 = sequencer owns the address
- `mem_cen_sel`  out  1  to controller chip-enable select; 1 = read issued this cycle
- `mem_data_in`  in  DATA_WIDTH  from controller data output
- `coef_data`  out  DATA_WIDTH  FIFO head word
- `coef_valid`  out  1  FIFO non-empty
- `coef_ready`  in  1  consumer accepts when `coef_valid`&`coef_ready`
- `coef_last`  out  1  head word is the final word of the transfer

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: `start`&`length`≠0 → latch base/length, FETCH. `start`&`length`=0 → `done` pulse next cycle, remain IDLE. `busy`=0.
- FETCH: each cycle, issue a read (`mem_cen_sel`=1, `mem_addr`=current) iff `fifo_count + inflight < FIFO_DEPTH`; `inflight` ∈ {0,1}. On issue, address +1, issued +1. When issued = length after an issue → DRAIN.
- Address arithmetic is modulo 2^15: 0x7FFF + 1 → 0x0000 (bank 7 wraps to bank 0).
- DRAIN: no issues; when FIFO empty, `inflight`=0 and last word accepted → `done` pulse, IDLE.
- Returned data: the cycle after an issue, `mem_data_in` is written into the FIFO; tag bit = (word index = length−1) is stored and drives `coef_last`.
- FIFO push and pop in the same cycle are both honoured; count unchanged.
- `start` while `busy`=1 is ignored (no latch, no error).
- `mem_addr_sel`=1 throughout FETCH and DRAIN, 0 in IDLE (system path owns the banks).
- Credit rule guarantees no FIFO overflow; push to a full FIFO cannot occur (assertion in bench).

## Timing
- All outputs registered except `coef_data`/`coef_valid`/`coef_last` (direct FIFO head).
- Reset values: `busy`=0, `done`=0, `mem_addr`=0, `mem_addr_sel`=0, `mem_cen_sel`=0, `coef_valid`=0, `coef_last`=0, `coef_data`=0; FIFO, counters, inflight cleared.
- `start` in cycle 0 → first issue in cycle 1 → `mem_data_in` valid cycle 2 → `coef_valid`=1 cycle 3.
- Throughput: one word/cycle with `coef_ready` held 1; N words, ready always 1 → last word accepted cycle N+2, `done` cycle N+3, `busy` low cycle N+4.
- `rst` mid-transfer: next cycle all state at reset values; in-flight memory return discarded; no `done`.

## Structure
- Package `coef_fetch_pkg`: FSM state enum, `FIFO_DEPTH` default, widths of count/pointer fields.
- Sub-module `coef_fifo`: synchronous FIFO, DATA_WIDTH+1 bits wide (data + last tag), outputs count, empty, full.
- Top holds FSM, address/issued counters, inflight flag, credit compare.

## Test plan
- Base 0x0000, length 8, ready=1 → addresses 0x0000–0x0007 on cycles 1–8, eight words in order, `coef_last` on word 8, `done` cycle 11.
- Base 0x7FFE, length 4, ready=1 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; bank select wraps 7→0; data order intact.
- Base 0x1000, length 16, ready=0 for 10 cycles then 1 → exactly 4 issues then stall; no overflow, no lost/duplicated word; all 16 delivered.
- Length 0 → no `mem_cen_sel`, `busy` stays 0, `done` one cycle after `start`.
- Length 1 at 0x2ABC → single issue, single word with `coef_last`=1; second `start` during `busy` ignored.
- `rst` asserted cycle 5 of a length-20 transfer → all outputs reset next cycle, no `done`; fresh `start` afterwards runs correctly.
